// File: rtl/prime_uart_tx.sv
// prime_uart_tx: converts one unsigned binary number per handshake to decimal
// ASCII (double dabble) and sends it as 8N1 UART frames followed by CR LF.
module prime_uart_tx #(
    parameter int WIDTH        = 16,
    parameter int DIGITS       = 5,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic [15:0]      sent_count
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNV_W  = $clog2(WIDTH + 1);
    localparam int BYTE_W = $clog2(DIGITS + 3);
    localparam int DIG_W  = $clog2(DIGITS + 1);

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, CONVERT, SCAN, SEND, FINISH} state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd;
    logic [WIDTH-1:0]   bin;
    logic [CNV_W-1:0]   cnv_cnt;
    logic [TMR_W-1:0]   bit_tmr;
    logic [3:0]         bit_idx;
    logic [BYTE_W-1:0]  byte_idx;
    logic [DIG_W-1:0]   n_digits;
    logic [7:0]         cur_byte;
    logic [7:0]         cur_shift;
    logic               tx_bit;
    logic               last_tick;
    logic               accept;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Number of digits to print: position of the top nonzero digit, at least one.
    function automatic logic [DIG_W-1:0] msd_count(input logic [BCD_W-1:0] b);
        logic [DIG_W-1:0] n;
        n = DIG_W'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (b[4*i +: 4] != 4'd0) n = DIG_W'(i + 1);
        end
        return n;
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_tick = (bit_tmr == TMR_MAX) && (bit_idx == 4'd9) &&
                       (byte_idx == BYTE_W'(n_digits) + BYTE_W'(1));

    // Select the byte being framed: digits MS first, then CR, then LF.
    always_comb begin
        cur_byte = 8'h0A;
        if (byte_idx == BYTE_W'(n_digits)) cur_byte = 8'h0D;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(byte_idx) + i + 1 == int'(n_digits)) cur_byte = {4'h3, bcd[4*i +: 4]};
        end
    end

    // Frame bit for the current bit index: start 0, data LSB first, stop 1.
    always_comb begin
        cur_shift = cur_byte >> (bit_idx - 4'd1);
        if (bit_idx == 4'd0)      tx_bit = 1'b0;
        else if (bit_idx == 4'd9) tx_bit = 1'b1;
        else                      tx_bit = cur_shift[0];
    end

    // Next-state logic for the accept / convert / scan / send sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CONVERT;
            CONVERT: if (cnv_cnt == CNV_W'(WIDTH - 1)) state_nxt = SCAN;
            SCAN:    state_nxt = SEND;
            SEND:    if (last_tick) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: state, handshake, registered tx line and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            tx         <= 1'b1;
            sent_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE);
            tx       <= (state == SEND) ? tx_bit : 1'b1;
            if (state == FINISH) sent_count <= sent_count + 16'd1;
        end
    end

    // Datapath: capture, double-dabble shifting, digit count and bit/byte timing.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    bin      <= in_data;
                    bcd      <= '0;
                    cnv_cnt  <= '0;
                    byte_idx <= '0;
                end
            end
            CONVERT: begin
                {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
                cnv_cnt    <= cnv_cnt + CNV_W'(1);
            end
            SCAN: begin
                n_digits <= msd_count(bcd);
                bit_tmr  <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
            end
            SEND: begin
                if (bit_tmr == TMR_MAX) begin
                    bit_tmr <= '0;
                    if (bit_idx == 4'd9) begin
                        bit_idx  <= '0;
                        byte_idx <= byte_idx + BYTE_W'(1);
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end else begin
                    bit_tmr <= bit_tmr + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prime_uart_tx.sv
// Bench for prime_uart_tx: UART monitor on tx, decimal-string reference model.
module tb_prime_uart_tx;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int CPB    = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             tx;
    logic [15:0]      sent_count;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         exp_sent = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         fall_q[$];

    prime_uart_tx #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .sent_count(sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // UART receiver: mid-bit sampling, frames cut by reset are discarded.
    initial begin : monitor
        logic [9:0] bits;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                fall_q.push_back(cyc);
                aborted = 1'b0;
                bits    = '0;
                for (int s = 0; s < 10 * CPB; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                    if (s % CPB == CPB / 2) bits[s / CPB] = tx;
                end
                if (!aborted) begin
                    check("frame_start_stop", 32'({bits[9], bits[0]}), 32'(2'b10));
                    rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    // Reference model: decimal text of the value, then CR LF.
    task automatic expect_num(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic int n_dec(input int v);
        string s;
        s = $sformatf("%0d", v);
        return s.len();
    endfunction

    task automatic check_bytes(input string tag);
        check($sformatf("%s_nbytes", tag), 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_ready(input string tag, output int at);
        at = -1;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (in_ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("%s_timeout", tag), 32'(in_ready), 32'(1));
    endtask

    task automatic accept(input int v, output int e);
        int dummy;
        if (in_ready !== 1'b1) wait_ready("pre_accept", dummy);
        in_valid = 1'b1;
        in_data  = 16'(v);
        @(posedge clk); #1;
        e = cyc;
        in_valid = 1'b0;
        check($sformatf("accept_%0d_ready_low", v), 32'(in_ready), 32'(0));
        fall_q.delete();
        expect_num(v);
    endtask

    task automatic complete(input int v, input int e, input string tag);
        int r;
        int first;
        wait_ready(tag, r);
        check({tag, "_ready_at"}, 32'(r - e), 32'(WIDTH + 2 + (n_dec(v) + 2) * 10 * CPB));
        first = (fall_q.size() > 0) ? fall_q[0] - e : -1;
        check({tag, "_first_fall"}, 32'(first), 32'(WIDTH + 2));
        check({tag, "_nframes"}, 32'(fall_q.size()), 32'(n_dec(v) + 2));
        exp_sent++;
        check({tag, "_sent"}, 32'(sent_count), 32'(exp_sent & 16'hFFFF));
        check({tag, "_tx_idle"}, 32'(tx), 32'(1));
        check_bytes(tag);
    endtask

    initial begin : stim
        int e;
        int e2;
        int r;
        int v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_tx", 32'(tx), 32'(1));
            check("rst_ready", 32'(in_ready), 32'(0));
            check("rst_sent", 32'(sent_count), 32'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'(1));
        check("post_rst_tx", 32'(tx), 32'(1));
        check("post_rst_sent", 32'(sent_count), 32'(0));

        // Single digit and zero.
        accept(2, e);
        complete(2, e, "n2");
        accept(0, e);
        complete(0, e, "n0");

        // in_valid held high across two numbers.
        in_valid = 1'b1;
        in_data  = 16'd65521;
        @(posedge clk); #1;
        e = cyc;
        check("hold1_ready_low", 32'(in_ready), 32'(0));
        fall_q.delete();
        expect_num(65521);
        in_data = 16'd65535;
        complete(65521, e, "n65521");
        @(posedge clk); #1;
        e2 = cyc;
        check("hold2_ready_low", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        fall_q.delete();
        expect_num(65535);
        complete(65535, e2, "n65535");

        // in_valid pulse while busy is ignored.
        accept(13, e);
        repeat (60) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'd7;
        check("busy_ready_low", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        complete(13, e, "n13");
        repeat (300) @(posedge clk);
        #1;
        check("ignored_no_bytes", 32'(rx_q.size()), 32'(0));
        check("ignored_sent", 32'(sent_count), 32'(exp_sent));

        // Reset during data bit 1 of the first digit of 1009.
        accept(1009, e);
        repeat (27) @(posedge clk);
        #1;
        check("mid_tx_low", 32'(tx), 32'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tx", 32'(tx), 32'(1));
        check("mid_rst_ready", 32'(in_ready), 32'(0));
        check("mid_rst_sent", 32'(sent_count), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sent = 0;
        @(posedge clk); #1;
        check("mid_post_ready", 32'(in_ready), 32'(1));
        repeat (45) @(posedge clk);
        #1;
        check("mid_no_bytes", 32'(rx_q.size()), 32'(0));
        check("mid_tx_idle", 32'(tx), 32'(1));
        exp_q.delete();
        fall_q.delete();
        accept(11, e);
        complete(11, e, "n11");

        // Random values with varying digit counts.
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range((i % 3 == 0) ? 99 : 65535, 0));
            accept(v, e);
            complete(v, e, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prime_uart_tx.md
Name: prime_uart_tx

Overview:
- Downstream consumer of primogen results on the icestick.
- Accepts one WIDTH-bit unsigned number per handshake and converts it to decimal ASCII.
- Transmits the number over the FTDI UART (8N1, LSB first) as digits followed by CR LF.
- The bench top instantiates it between primogen's result/ready path and the tx pin, so primes can be logged on a host terminal.

Parameters:
- WIDTH, 16, bit width of the input number.
- DIGITS, 5, BCD digit slots. Must satisfy 10^DIGITS > 2^WIDTH-1; violating this is a configuration error and is not checked in RTL.
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200). Minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data holds a number to print.
- in_data  in  WIDTH  unsigned number.
- in_ready  out  1  block idle and able to accept.
- tx  out  1  UART line, idle high.
- sent_count  out  16  numbers fully transmitted; wraps 0xFFFF -> 0.

Behaviour:
- Reset values, applied at the edge where rst=1:
  - tx=1, in_ready=0, sent_count=0, state=IDLE.
  - in_ready goes to 1 on the first edge with rst=0.
- Reset mid-operation: same as above. A partial frame is abandoned and tx returns high on that edge; no recovery byte is sent.
- Accept: at edge E with in_valid && in_ready:
  - in_data is captured into the shift register.
  - in_ready=0 from E onwards.
  - in_data is ignored until in_ready returns to 1.
- in_valid while in_ready=0: no effect, nothing queued.
- State IDLE: in_ready=1, tx=1. On accept -> CONVERT.
- State CONVERT (double dabble):
  - Exactly WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left 1.
  - After WIDTH cycles -> SCAN.
- State SCAN:
  - 1 cycle.
  - Locates the most significant nonzero digit.
  - If all digits are zero, the single digit '0' is sent.
  - Leading zeros are never sent.
  - -> SEND.
- State SEND:
  - Sends digits MS to LS as 8'h30+digit, then 8'h0D, then 8'h0A.
  - Each byte is one frame:
    - start bit (0), CLKS_PER_BIT cycles;
    - 8 data bits LSB first, CLKS_PER_BIT each;
    - stop bit (1), CLKS_PER_BIT cycles.
  - Frames are back-to-back with no idle gap.
  - tx of the first start bit falls at edge E+WIDTH+2.
- Completion, at the edge ending the LF stop bit:
  - sent_count increments;
  - in_ready=1;
  - state -> IDLE.
- Total busy time from accept to in_ready=1: WIDTH + 2 + (n+2)*10*CLKS_PER_BIT cycles, where n is the number of printed digits (1..DIGITS).
- Bit timer: counts 0..CLKS_PER_BIT-1. Bit index 0..9 within the frame. The byte index resets at each accept.
- tx is a registered output with no glitches.
- Maximum input 2^WIDTH-1 (65535 at defaults) prints all DIGITS digits.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and WIDTH=16; the bench decodes tx with a UART monitor.
- Reset: rst high for 3 cycles, then low -> tx=1 throughout, in_ready=0 during rst and 1 on the first edge after, sent_count=0.
- in_data=2 accepted -> bytes 0x32 0x0D 0x0A. First tx fall at E+18. in_ready back at E+18+120. sent_count=1.
- in_data=0 -> bytes 0x30 0x0D 0x0A (single '0', no leading zeros).
- in_data=65521 then in_data=65535, with in_valid held high continuously -> "65521\r\n65535\r\n". The second number is accepted only on the in_ready edge. sent_count=2.
- in_valid pulsed with in_data=7 during transmission of "13" -> ignored. Only "13\r\n" is received and sent_count increments once.
- rst asserted during the second data bit of the first digit of 1009 -> tx=1 on the next edge, in_ready=1 one edge after rst drops, sent_count=0. A subsequent accept of 11 yields "11\r\n".
